// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared state encoding and default pattern for the pattern transmitter
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } tx_state_t;

    // Also the reference sequence for the 10010 detector benches.
    localparam logic [4:0] DEFAULT_PATTERN = 5'b10010;

endpackage

// File: rtl/pattern_shifter.sv
// rtl/pattern_shifter.sv - loadable MSB-first shift register that backfills with the idle level
module pattern_shifter #(
    parameter int   PLEN = 5,
    parameter logic FILL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PLEN-1:0] din,
    input  logic            load,
    input  logic            shift,
    input  logic            clr,
    output logic            q
);

    logic [PLEN-1:0] sreg;

    // After PLEN shifts the register holds only FILL, so q idles without extra muxing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= {PLEN{FILL}};
        end else if (clr) begin
            sreg <= {PLEN{FILL}};
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[PLEN-2:0], FILL};
        end
    end

    assign q = sreg[PLEN-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - repeats a fixed bit pattern serially with optional idle gaps between repetitions
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int              PLEN     = 5,
    parameter logic [PLEN-1:0] PATTERN  = DEFAULT_PATTERN,
    parameter int              GAP      = 1,
    parameter logic            IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] reps,
    input  logic       abort,
    output logic       J,
    output logic       valid,
    output logic       frame_start,
    output logic       busy,
    output logic       done
);

    localparam int            IW       = $clog2(PLEN);
    localparam logic [IW-1:0] IDX_TOP  = IW'(PLEN - 1);
    localparam logic [2:0]    GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    tx_state_t     state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [3:0]    rep_cnt, rep_n;
    logic [2:0]    gap_cnt, gap_n;
    logic          load, shift, clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            rep_cnt     <= rep_n;
            gap_cnt     <= gap_n;
            valid       <= (state_n == ST_SEND);
            frame_start <= load;
            busy        <= (state_n == ST_SEND) || (state_n == ST_GAP);
            done        <= (state_n == ST_FIN);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep_cnt;
        gap_n   = gap_cnt;
        load    = 1'b0;
        shift   = 1'b0;
        clr     = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            rep_n   = '0;
            gap_n   = '0;
            clr     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (reps != 4'd0) begin
                            state_n = ST_SEND;
                            rep_n   = reps;
                            idx_n   = IDX_TOP;
                            load    = 1'b1;
                        end else begin
                            state_n = ST_FIN;
                        end
                    end
                end
                ST_SEND: begin
                    if (idx != '0) begin
                        idx_n = idx - 1'b1;
                        shift = 1'b1;
                    end else if (rep_cnt > 4'd1) begin
                        rep_n = rep_cnt - 4'd1;
                        if (GAP == 0) begin
                            idx_n = IDX_TOP;
                            load  = 1'b1;
                        end else begin
                            state_n = ST_GAP;
                            gap_n   = GAP_LAST;
                            shift   = 1'b1;
                        end
                    end else begin
                        // Last repetition: no trailing gap.
                        state_n = ST_FIN;
                        rep_n   = '0;
                        shift   = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 3'd0) begin
                        state_n = ST_SEND;
                        idx_n   = IDX_TOP;
                        load    = 1'b1;
                    end else begin
                        gap_n = gap_cnt - 3'd1;
                    end
                end
                ST_FIN:  state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    pattern_shifter #(
        .PLEN (PLEN),
        .FILL (IDLE_BIT)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .din   (PATTERN),
        .load  (load),
        .shift (shift),
        .clr   (clr),
        .q     (J)
    );

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx against a stream-level reference model
module tb_pattern_tx;

    localparam int         PLEN = 5;
    localparam logic [4:0] PAT  = 5'b10010;
    localparam int         GAP  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic [3:0] reps = 4'd0;
    logic       J, valid, fs, busy, done;

    logic       start0 = 1'b0;
    logic [3:0] reps0 = 4'd0;
    logic       abort0 = 1'b0;
    logic       j0, valid0, fs0, busy0, done0;

    int n_total = 0;
    int n_pass  = 0;

    logic [4:0] expq[$];

    always #5 clk = ~clk;

    pattern_tx u_dut (
        .clk(clk), .rst(rst), .start(start), .reps(reps), .abort(abort),
        .J(J), .valid(valid), .frame_start(fs), .busy(busy), .done(done)
    );

    pattern_tx #(.GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .start(start0), .reps(reps0), .abort(abort0),
        .J(j0), .valid(valid0), .frame_start(fs0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected per-cycle {J, valid, frame_start, busy, done} from the transmission rules.
    function automatic void build(input int r, input int gap);
        expq.delete();
        for (int rep = 0; rep < r; rep++) begin
            for (int b = 0; b < PLEN; b++) begin
                logic bitv;
                bitv = 1'((PAT >> (PLEN - 1 - b)) & 5'd1);
                expq.push_back({bitv, 1'b1, (b == 0), 1'b1, 1'b0});
            end
            if (rep < r - 1)
                for (int g = 0; g < gap; g++) expq.push_back(5'b00010);
        end
        expq.push_back(5'b00001);
    endfunction

    // Call just after a negedge; start is accepted at the following posedge.
    task automatic run_frame(input int r, input bit disturb);
        int fs_seen, done_seen;
        fs_seen = 0;
        done_seen = 0;
        build(r, GAP);
        start = 1'b1;
        reps  = 4'(r);
        for (int k = 0; k < expq.size(); k++) begin
            @(negedge clk);
            chk($sformatf("frame r=%0d cyc=%0d", r, k + 1), {27'd0, J, valid, fs, busy, done}, {27'd0, expq[k]});
            fs_seen += int'(fs);
            done_seen += int'(done);
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                reps  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk($sformatf("frame_start count r=%0d", r), fs_seen, r);
        chk($sformatf("done count r=%0d", r), done_seen, 1);
        @(negedge clk);
        chk("idle after frame", {28'd0, valid, fs, busy, done}, 32'd0);
    endtask

    initial begin
        logic [4:0]  win;
        logic [15:0] hits;

        // Reset state
        @(negedge clk);
        chk("reset outputs", {27'd0, J, valid, fs, busy, done}, 32'd0);
        rst = 1'b0;

        // Single repetition, then two with one gap cycle
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);

        // Random repetition counts with start/reps churn during transmission
        repeat (6) begin
            run_frame($urandom_range(1, 4), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle between frames", {28'd0, valid, fs, busy, done}, 32'd0);
            end
        end

        // reps=0 -> immediate done, no valid bits
        run_frame(0, 1'b0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; reps = 4'd2;
        repeat (3) begin
            @(negedge clk);
            chk("start+abort idle", {27'd0, J, valid, fs, busy, done}, 32'd0);
        end
        start = 1'b0; abort = 1'b0;

        // Abort on cycle 3 of reps=3
        start = 1'b1; reps = 4'd3;
        @(negedge clk); start = 1'b0;
        chk("abort run cyc1", {30'd0, J, valid}, {30'd0, 1'b1, 1'b1});
        @(negedge clk);
        @(negedge clk);
        chk("abort run cyc3", {30'd0, J, valid}, {30'd0, 1'b0, 1'b1});
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("after abort", {27'd0, J, valid, fs, busy, done}, 32'd0);
        @(negedge clk);
        chk("no done after abort", {27'd0, J, valid, fs, busy, done}, 32'd0);
        run_frame(1, 1'b0);

        // Loop-back into a 10010 detector with GAP=0
        win = 5'd0;
        hits = 16'd0;
        start0 = 1'b1; reps0 = 4'd2;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            win = {win[3:0], j0};
            if (win == 5'b10010) hits[k] = 1'b1;
            if (k == 11) chk("g0 done", {31'd0, done0}, 32'd1);
            if (k <= 10) chk($sformatf("g0 valid cyc=%0d", k), {31'd0, valid0}, 32'd1);
        end
        chk("detector hits", {16'd0, hits}, 32'h0000_0420);

        // Asynchronous reset in the middle of SEND, then reps=15
        start = 1'b1; reps = 4'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy before rst", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("async reset outputs", {27'd0, J, valid, fs, busy, done}, 32'd0);
        @(negedge clk);
        chk("held in reset", {27'd0, J, valid, fs, busy, done}, 32'd0);
        rst = 1'b0;
        run_frame(15, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PLEN, default 5, pattern length in bits (2..16).
REQ-002 Parameter PATTERN, default 5'b10010, PLEN-bit pattern, transmitted MSB first.
REQ-003 Parameter GAP, default 1, idle cycles between repetitions (0..7).
REQ-004 Parameter IDLE_BIT, default 1'b0, value of J when no pattern bit is driven.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start  in  1  request to begin a transmission; sampled only in IDLE.
REQ-008 reps  in  4  number of pattern repetitions; latched when start is accepted.
REQ-009 abort  in  1  terminate the current transmission.
REQ-010 J  out  1  serial pattern bit; registered.
REQ-011 valid  out  1  high in every cycle that J carries a pattern bit.
REQ-012 frame_start  out  1  high with the first (MSB) bit of each repetition.
REQ-013 busy  out  1  high in SEND and GAP states.
REQ-014 done  out  1  one-cycle pulse at normal completion.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and FIN, with IDLE as the reset state.
REQ-016 In IDLE with start=1, abort=0 and reps>0, the FSM SHALL go to SEND, latch reps, and set the bit index to PLEN-1.
REQ-017 In IDLE with start=1, abort=0 and reps=0, the FSM SHALL go to FIN without driving any valid bit.
REQ-018 The first pattern bit SHALL appear on J, with valid=1 and frame_start=1, in the cycle after the edge that accepts start (latency 1).
REQ-019 In SEND, J SHALL equal PATTERN[index] and valid SHALL be 1; the index SHALL decrement by 1 per cycle.
REQ-020 At index 0 with repetitions remaining >1, the FSM SHALL go to GAP for GAP cycles, or directly to SEND with index PLEN-1 when GAP=0.
REQ-021 At index 0 of the last repetition, the FSM SHALL go to FIN; GAP cycles SHALL NOT follow the last repetition.
REQ-022 In GAP, J SHALL be IDLE_BIT and valid SHALL be 0; after GAP cycles the FSM SHALL re-enter SEND with index PLEN-1.
REQ-023 FIN SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 start SHALL be ignored in SEND, GAP and FIN; reps changes after acceptance SHALL have no effect.
REQ-025 abort=1 in any state SHALL force IDLE at the next edge with J=IDLE_BIT and valid=0, and SHALL NOT produce done.
REQ-026 Simultaneous start and abort in IDLE SHALL leave the FSM in IDLE (abort wins).
REQ-027 The repetition counter SHALL be 4 bits wide, so reps=15 yields exactly 15 repetitions without wrap.
REQ-028 The bit index SHALL be $clog2(PLEN) bits wide, and the gap counter SHALL be 3 bits wide.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, J=IDLE_BIT, valid=0, frame_start=0, busy=0, done=0, with all counters at 0.
REQ-030 Reset asserted mid-transmission SHALL take effect immediately and asynchronously, with no done pulse.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'b00, SEND=2'b01, GAP=2'b10, FIN=2'b11) and the default PATTERN constant 5'b10010 used by both the transmitter and the 10010 detector benches.
REQ-033 A single sub-module, pattern_shifter (a PLEN-bit loadable MSB-first shift register with a load/shift enable), SHALL be used; the FSM and counters SHALL stay in pattern_tx.

Verification
REQ-034 Defaults, reps=1, one-cycle start -> J=1,0,0,1,0 on cycles 1..5 with valid=1, frame_start on cycle 1, done on cycle 6, busy=0 from cycle 6.
REQ-035 reps=2, GAP=1 -> J stream 1,0,0,1,0,0,1,0,0,1,0; valid=0 on cycle 6; frame_start on cycles 1 and 7; done on cycle 12.
REQ-036 Loop-back: J drives the Mealy 10010 detector, reps=2, GAP=0 -> detector output w pulses exactly twice, on the 5th and 10th bits.
REQ-037 abort on cycle 3 of reps=3 -> IDLE next edge, valid=0, no done pulse; a new start two cycles later transmits a full pattern.
REQ-038 reps=0 with start -> no valid, done high on cycle 1 only; start=abort=1 in IDLE -> no activity.
REQ-039 rst pulsed mid-SEND -> all outputs at reset values immediately, no done pulse; start with reps=15 after reset -> 15 frame_start pulses, then one done.
